// File: rtl/cpu_clk_ctrl.sv
// Core clock-enable and reset controller: stretched synchronised core reset plus a one-cycle
// core enable from a programmable divider or a debounced step button. CPU_CLK_CTRL_BURST_EN adds burst stepping.
module cpu_clk_ctrl #(
    parameter int DIV_WIDTH  = 8,
    parameter int RST_HOLD   = 4,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_choose,
    input  logic [DIV_WIDTH-1:0] div_sel,
    input  logic                 step_btn,
    input  logic                 halt,
`ifdef CPU_CLK_CTRL_BURST_EN
    input  logic [7:0]           burst_len,
`endif
    output logic                 cpu_rst_n,
    output logic                 cpu_ce,
    output logic                 mode,
    output logic [CNT_WIDTH-1:0] ce_count
);

    // state    | meaning
    // R_ASSERT | core held in reset, waiting for synchronised rst release
    // R_HOLD   | stretching the core reset
    // R_RUN    | core out of reset
    // M_DIV    | cpu_ce from the divider
    // M_MAN    | cpu_ce from debounced step button
    // M_SWITCH | one quiet cycle after a mode change
    typedef enum logic [1:0] {R_ASSERT, R_HOLD, R_RUN} rst_state_t;
    typedef enum logic [1:0] {M_DIV, M_MAN, M_SWITCH} mode_state_t;

    localparam int HOLD_W = (RST_HOLD > 2) ? $clog2(RST_HOLD - 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((RST_HOLD >= 2) ? RST_HOLD - 2 : 0);
    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]           rst_sync_q, choose_sync_q, btn_sync_q;
    rst_state_t           rst_state_q, rst_state_d;
    mode_state_t          mode_state_q, mode_state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic                 deb_level_q, deb_level_d;
    logic                 cpu_rst_n_q, cpu_ce_q, cpu_ce_d, mode_q, mode_d;
    logic [CNT_WIDTH-1:0] ce_count_q;
    logic                 choose_s, btn_s, run, div_hit, press;
`ifdef CPU_CLK_CTRL_BURST_EN
    logic                 burst_active_q, burst_active_d;
    logic [7:0]           burst_left_q, burst_left_d;
`endif

    assign choose_s = choose_sync_q[1];
    assign btn_s    = btn_sync_q[1];
    assign run      = cpu_rst_n_q;
    assign div_hit  = (div_cnt_q >= div_sel);

    // The ASSERT->HOLD edge is the first hold cycle, so release to cpu_rst_n is 2+RST_HOLD edges.
    always_comb begin
        rst_state_d = rst_state_q;
        hold_cnt_d  = hold_cnt_q;
        case (rst_state_q)
            R_ASSERT: if (rst_sync_q[1]) begin
                if (RST_HOLD == 1) begin
                    rst_state_d = R_RUN;
                end else begin
                    rst_state_d = R_HOLD;
                    hold_cnt_d  = HOLD_LOAD;
                end
            end
            R_HOLD: begin
                if (hold_cnt_q == '0) rst_state_d = R_RUN;
                else                  hold_cnt_d  = hold_cnt_q - HOLD_W'(1);
            end
            R_RUN:   rst_state_d = R_RUN;
            default: rst_state_d = R_ASSERT;
        endcase
    end

    always_comb begin
        mode_state_d = mode_state_q;
        mode_d       = mode_q;
        case (mode_state_q)
            M_DIV:    if (choose_s)  mode_state_d = M_SWITCH;
            M_MAN:    if (!choose_s) mode_state_d = M_SWITCH;
            M_SWITCH: mode_state_d = choose_s ? M_MAN : M_DIV;
            default:  mode_state_d = M_DIV;
        endcase
        if (mode_state_d == M_DIV) mode_d = 1'b0;
        if (mode_state_d == M_MAN) mode_d = 1'b1;
    end

    always_comb begin
        div_cnt_d   = div_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        deb_level_d = deb_level_q;
        cpu_ce_d    = 1'b0;
        press       = 1'b0;
`ifdef CPU_CLK_CTRL_BURST_EN
        burst_active_d = burst_active_q;
        burst_left_d   = burst_left_q;
`endif
        case (mode_state_q)
            M_SWITCH: begin
                div_cnt_d   = '0;
                deb_cnt_d   = '0;
                deb_level_d = btn_s;
`ifdef CPU_CLK_CTRL_BURST_EN
                burst_active_d = 1'b0;
`endif
            end
            M_DIV: if (run && !halt) begin
                if (div_hit) begin
                    div_cnt_d = '0;
                    cpu_ce_d  = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end
            M_MAN: begin
                if (btn_s != deb_level_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        deb_cnt_d   = '0;
                        deb_level_d = btn_s;
                        press       = btn_s;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
`ifdef CPU_CLK_CTRL_BURST_EN
                // Presses during a burst are dropped; the divider paces the remaining pulses.
                if (burst_active_q) begin
                    if (!halt) begin
                        if (div_hit) begin
                            cpu_ce_d     = 1'b1;
                            div_cnt_d    = '0;
                            burst_left_d = burst_left_q - 8'd1;
                            if (burst_left_q == 8'd1) burst_active_d = 1'b0;
                        end else begin
                            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                        end
                    end
                end else if (press && run && !halt) begin
                    cpu_ce_d       = 1'b1;
                    div_cnt_d      = '0;
                    burst_left_d   = burst_len;
                    burst_active_d = (burst_len != 8'd0);
                end
`else
                if (press && run && !halt) cpu_ce_d = 1'b1;
`endif
            end
            default: cpu_ce_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q    <= '0;
            choose_sync_q <= '0;
            btn_sync_q    <= '0;
            rst_state_q   <= R_ASSERT;
            hold_cnt_q    <= '0;
            mode_state_q  <= M_DIV;
            mode_q        <= 1'b0;
            div_cnt_q     <= '0;
            deb_cnt_q     <= '0;
            deb_level_q   <= 1'b0;
            cpu_rst_n_q   <= 1'b0;
            cpu_ce_q      <= 1'b0;
            ce_count_q    <= '0;
        end else begin
            rst_sync_q    <= {rst_sync_q[0], 1'b1};
            choose_sync_q <= {choose_sync_q[0], clk_choose};
            btn_sync_q    <= {btn_sync_q[0], step_btn};
            rst_state_q   <= rst_state_d;
            hold_cnt_q    <= hold_cnt_d;
            mode_state_q  <= mode_state_d;
            mode_q        <= mode_d;
            div_cnt_q     <= div_cnt_d;
            deb_cnt_q     <= deb_cnt_d;
            deb_level_q   <= deb_level_d;
            cpu_rst_n_q   <= (rst_state_d == R_RUN);
            cpu_ce_q      <= cpu_ce_d;
            ce_count_q    <= ce_count_q + CNT_WIDTH'(cpu_ce_q);
        end
    end

`ifdef CPU_CLK_CTRL_BURST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_active_q <= 1'b0;
            burst_left_q   <= '0;
        end else begin
            burst_active_q <= burst_active_d;
            burst_left_q   <= burst_left_d;
        end
    end
`endif

    assign cpu_rst_n = cpu_rst_n_q;
    assign cpu_ce    = cpu_ce_q;
    assign mode      = mode_q;
    assign ce_count  = ce_count_q;

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Clock-enable and reset controller between the board clock (clk_50 domain) and the THCO-MIPS core.
- Replaces free-running bench clock/reset generation with a synthesizable block.
- Produces a stretched, synchronised core reset.
- Produces a single-cycle core clock-enable from either a programmable divider or a debounced manual step button, selected by clk_choose.

Parameters:
DIV_WIDTH, 8, width of divide-ratio input and divider counter
RST_HOLD, 4, cycles core reset stays asserted after synchronised rst release (>=1)
DEB_CYCLES, 16, consecutive stable cycles required to accept a step_btn level change (>=2)
CNT_WIDTH, 32, width of ce_count

Ports:
clk  input  1  board clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
clk_choose  input  1  mode select, asynchronous: 0 = divided auto clock, 1 = manual step
div_sel  input  DIV_WIDTH  divide ratio; ce period = div_sel+1 cycles
step_btn  input  1  raw manual-step button, asynchronous, active-high
halt  input  1  synchronous; 1 suppresses ce and freezes divider
cpu_rst_n  output  1  core reset, active-low, registered
cpu_ce  output  1  core clock enable, one-cycle pulse, registered
mode  output  1  current effective mode (synchronised clk_choose)
ce_count  output  CNT_WIDTH  number of cpu_ce pulses since reset

Behaviour:
- Reset values, forced while rst=0: cpu_rst_n=0, cpu_ce=0, mode=0, ce_count=0, all counters/synchronisers 0.
- Reset FSM: R_ASSERT -> R_HOLD -> R_RUN.
  - R_ASSERT: waits for a 2-flop synchroniser of rst (async set-low, sync release) to read 1.
  - R_HOLD: counts RST_HOLD cycles.
  - R_RUN: cpu_rst_n=1.
  - rst release to cpu_rst_n=1 takes exactly 2+RST_HOLD rising edges.
  - rst low at any time: immediate async return to R_ASSERT, cpu_rst_n=0 same instant.
- cpu_ce is 0 whenever cpu_rst_n=0 or halt=1. No ce pulse may be generated in the cycle cpu_rst_n rises.
- clk_choose and step_btn each pass through a 2-flop synchroniser.
- Mode FSM: M_DIV, M_MAN, M_SWITCH.
  - A change of synchronised clk_choose enters M_SWITCH for exactly one cycle: divider counter cleared, debouncer state reloaded with current synchronised step_btn level, no ce.
  - Then goes to M_DIV (0) or M_MAN (1). mode output updates on entry to the new state.
- Divider (M_DIV, halt=0):
  - div_cnt increments each cycle.
  - When div_cnt >= div_sel: cpu_ce=1 next cycle, div_cnt<=0.
  - div_sel=0 gives ce every cycle.
  - Lowering div_sel below the current div_cnt fires on the next cycle and wraps (no lockup).
  - halt=1 freezes div_cnt, no ce. A pending terminal count fires after halt drops.
- Manual (M_MAN):
  - deb_cnt counts cycles where synchronised step_btn differs from deb_level; it resets to 0 on agreement.
  - At DEB_CYCLES, deb_level flips.
  - A 0->1 flip of deb_level gives exactly one cpu_ce pulse (next cycle); a 1->0 flip gives none.
  - Holding the button gives one pulse only.
  - Bounces shorter than DEB_CYCLES give no pulse.
  - A press accepted while halt=1 is discarded (not queued).
- ce_count increments on every cpu_ce=1 cycle, wraps modulo 2^CNT_WIDTH, cleared only by rst.
- Latency from qualifying event to cpu_ce high: 1 cycle (registered output).

Optional Feature:
- Macro: CPU_CLK_CTRL_BURST_EN.
- When defined:
  - Adds input burst_len [7:0].
  - In M_MAN, each accepted press issues burst_len+1 ce pulses, spaced div_sel+1 cycles apart using the divider.
  - halt pauses the burst, which resumes afterward.
  - Mode switch or rst aborts the burst.
  - A press during a burst is ignored.
- When undefined: no burst_len port; one press = one pulse.

Test Plan:
- Reset sequence, RST_HOLD=4: rst=0 for 5 cycles, then 1 -> cpu_rst_n rises on the 6th edge after release; cpu_ce=0 and ce_count=0 throughout.
- Divider rates, div_sel=3, clk_choose=0: 40 cycles after cpu_rst_n=1 -> 10 pulses exactly 4 cycles apart. div_sel=0 -> ce continuous. div_sel changed from 9 to 2 while div_cnt=6 -> pulse next cycle, then period 3.
- Halt mid-count, div_sel=3: halt=1 for 10 cycles at div_cnt=2 -> no ce; after release, pulse after 2 cycles; ce_count shows no lost or extra pulses.
- Debounce, clk_choose=1, DEB_CYCLES=16: step_btn toggled every 5 cycles for 60 cycles, then held 1 for 100 cycles -> zero pulses during bouncing, then exactly one pulse; release and press again -> ce_count=2.
- Mode switch and mid-operation reset: toggle clk_choose while div_cnt=2 -> 2 synchroniser + 1 switch cycle with no ce, mode flips. Pulse rst low for 1 cycle mid-run -> cpu_rst_n and cpu_ce drop immediately, ce_count=0.
- With CPU_CLK_CTRL_BURST_EN, burst_len=2, div_sel=1: one accepted press -> 3 pulses 2 cycles apart; second press during burst -> ignored, total ce_count=3.
